// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-index constants and the action-to-strobe decode.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_INIT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_LOAD_STALL = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } ctrl_state_e;

  // What the pipeline does this cycle; every strobe pattern derives from one of these.
  typedef enum logic [2:0] {
    ACT_INIT,
    ACT_GO,
    ACT_BUBBLE,
    ACT_FLUSH,
    ACT_FREEZE
  } ctrl_action_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
  } strobe_t;

  function automatic strobe_t action_strobes(input ctrl_action_e act);
    strobe_t s;
    s = '0;
    case (act)
      ACT_INIT: begin
        s.ifid_flush = 1'b1;
        s.idex_flush = 1'b1;
      end
      ACT_GO: begin
        s.pc_en    = 1'b1;
        s.ifid_en  = 1'b1;
        s.idex_en  = 1'b1;
        s.exmem_en = 1'b1;
      end
      ACT_BUBBLE: begin
        s.idex_en    = 1'b1;
        s.idex_flush = 1'b1;
        s.exmem_en   = 1'b1;
      end
      ACT_FLUSH: begin
        s = '1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a dependence).
module hazard_detect_unit #(
  parameter int ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              idex_mem_read,
  input  logic [ADDR_W-1:0] idex_rd,
  output logic              load_use
);
  import pipe_ctrl_pkg::*;

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_nonzero = (idex_rd != ADDR_W'(REG_X0));
  assign rs1_hit    = id_uses_rs1 && (id_rs1 == idex_rd);
  assign rs2_hit    = id_uses_rs2 && (id_rs2 == idex_rd);
  assign load_use   = idex_mem_read && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer for the in-order RV32I core: load-use bubbles,
// mispredict flushes and data-memory freezes. Optional PIPE_PERF_CNT_EN adds perf counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = pipe_ctrl_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  ex_mispredict,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic [1:0]            ctrl_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count,
  output logic [31:0]           memwait_cycles
`endif
);
  import pipe_ctrl_pkg::*;

  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_stall_cycles
    $error("pipeline_hazard_ctrl: LOAD_STALL_CYCLES must be within 1..7");
  end

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  ctrl_state_e  state, state_next, ctx;
  ctrl_action_e action;
  strobe_t      strobes;
  logic [2:0]   stall_cnt, stall_cnt_next;
  logic         ret_ls, ret_ls_next;
  logic         pend_mp, pend_mp_next;
  logic         load_use;
  logic         mem_stall;
  logic         mp_eff;

  hazard_detect_unit #(.ADDR_W(REG_ADDR_W)) u_hazard (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .load_use      (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;
  assign mp_eff    = ex_mispredict || pend_mp;

  // A MEM_WAIT release cycle behaves exactly like the context it resumes, so
  // decode from that context rather than from the raw state register.
  always_comb begin
    ctx = state;
    if (state == ST_MEM_WAIT && mem_ready)
      ctx = ret_ls ? ST_LOAD_STALL : ST_RUN;

    action         = ACT_FREEZE;
    state_next     = state;
    stall_cnt_next = stall_cnt;
    ret_ls_next    = ret_ls;
    pend_mp_next   = pend_mp;

    case (ctx)
      ST_INIT: begin
        action     = ACT_INIT;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall) begin
          action      = ACT_FREEZE;
          state_next  = ST_MEM_WAIT;
          ret_ls_next = 1'b0;
        end else if (mp_eff) begin
          action     = ACT_FLUSH;
          state_next = ST_RUN;
        end else if (load_use) begin
          action         = ACT_BUBBLE;
          stall_cnt_next = STALL_RELOAD;
          state_next     = (STALL_RELOAD == 3'd0) ? ST_RUN : ST_LOAD_STALL;
        end else begin
          action     = ACT_GO;
          state_next = ST_RUN;
        end
      end
      ST_LOAD_STALL: begin
        if (mem_stall) begin
          action      = ACT_FREEZE;
          state_next  = ST_MEM_WAIT;
          ret_ls_next = 1'b1;
        end else if (mp_eff) begin
          action         = ACT_FLUSH;
          state_next     = ST_RUN;
          stall_cnt_next = 3'd0;
        end else begin
          action = ACT_BUBBLE;
          if (stall_cnt <= 3'd1) begin
            stall_cnt_next = 3'd0;
            state_next     = ST_RUN;
          end else begin
            stall_cnt_next = stall_cnt - 3'd1;
            state_next     = ST_LOAD_STALL;
          end
        end
      end
      default: begin
        action     = ACT_FREEZE;
        state_next = ST_MEM_WAIT;
      end
    endcase

    // A mispredict seen while frozen is held until the first cycle that can flush.
    if (action == ACT_FREEZE)
      pend_mp_next = pend_mp || ex_mispredict;
    else if (action == ACT_FLUSH)
      pend_mp_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      stall_cnt <= 3'd0;
      ret_ls    <= 1'b0;
      pend_mp   <= 1'b0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      ret_ls    <= ret_ls_next;
      pend_mp   <= pend_mp_next;
    end
  end

  assign strobes    = action_strobes(action);
  assign pc_en      = strobes.pc_en;
  assign ifid_en    = strobes.ifid_en;
  assign ifid_flush = strobes.ifid_flush;
  assign idex_en    = strobes.idex_en;
  assign idex_flush = strobes.idex_flush;
  assign exmem_en   = strobes.exmem_en;
  assign ctrl_state = state;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= '0;
      flush_count    <= '0;
      memwait_cycles <= '0;
    end else begin
      if (action == ACT_BUBBLE)
        stall_cycles <= stall_cycles + 32'd1;
      if (action == ACT_FLUSH)
        flush_count <= flush_count + 32'd1;
      if (state == ST_MEM_WAIT)
        memwait_cycles <= memwait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: two instances (1 and 3 stall
// cycles) share stimulus and are compared against a behavioural pipeline model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int NDUT = 2;
  localparam logic [5:0] S_INIT   = 6'b001010;
  localparam logic [5:0] S_FREEZE = 6'b000000;
  localparam logic [5:0] S_FLUSH  = 6'b111111;
  localparam logic [5:0] S_BUBBLE = 6'b000111;
  localparam logic [5:0] S_GO     = 6'b110101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, idex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, idex_mem_read = 1'b0;
  logic       ex_mispredict = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  wire [5:0] stb [NDUT];
  wire [1:0] st  [NDUT];
`ifdef PIPE_PERF_CNT_EN
  wire [31:0] pc_stall [NDUT];
  wire [31:0] pc_flush [NDUT];
  wire [31:0] pc_mw    [NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pipeline_hazard_ctrl #(
      .LOAD_STALL_CYCLES((g == 0) ? 1 : 3),
      .REG_ADDR_W(5)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_uses_rs1   (id_uses_rs1),
      .id_uses_rs2   (id_uses_rs2),
      .idex_mem_read (idex_mem_read),
      .idex_rd       (idex_rd),
      .ex_mispredict (ex_mispredict),
      .mem_req       (mem_req),
      .mem_ready     (mem_ready),
      .pc_en         (stb[g][5]),
      .ifid_en       (stb[g][4]),
      .ifid_flush    (stb[g][3]),
      .idex_en       (stb[g][2]),
      .idex_flush    (stb[g][1]),
      .exmem_en      (stb[g][0]),
      .ctrl_state    (st[g])
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cycles  (pc_stall[g]),
      .flush_count   (pc_flush[g]),
      .memwait_cycles(pc_mw[g])
`endif
    );
  end

  // Reference model: pipeline condition tracked as "waiting on init", "frozen
  // on memory", "bubbles still owed" and "mispredict owed".
  int         lsc      [NDUT] = '{1, 3};
  bit         m_init   [NDUT];
  bit         m_frz    [NDUT];
  bit         m_pend   [NDUT];
  int         m_left   [NDUT];
  logic [5:0] exp_stb  [NDUT];
  logic [1:0] exp_st   [NDUT];
  logic [31:0] m_stall [NDUT];
  logic [31:0] m_flush [NDUT];
  logic [31:0] m_mw    [NDUT];

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NDUT; k++) begin
      m_init[k]  = 1'b1;
      m_frz[k]   = 1'b0;
      m_pend[k]  = 1'b0;
      m_left[k]  = 0;
      m_stall[k] = '0;
      m_flush[k] = '0;
      m_mw[k]    = '0;
    end
  endtask

  task automatic modelStep();
    bit lu, mstall, mp;
    lu = idex_mem_read && (idex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));
    mstall = mem_req && !mem_ready;
    mp     = ex_mispredict;
    for (int k = 0; k < NDUT; k++) begin
      exp_st[k] = m_init[k] ? 2'd0 : m_frz[k] ? 2'd3 : (m_left[k] > 0) ? 2'd2 : 2'd1;
      if (exp_st[k] == 2'd3) m_mw[k]++;
      if (m_init[k]) begin
        exp_stb[k] = S_INIT;
        m_init[k]  = 1'b0;
      end else if (m_frz[k] ? !mem_ready : mstall) begin
        exp_stb[k] = S_FREEZE;
        m_frz[k]   = 1'b1;
        m_pend[k]  = m_pend[k] | mp;
      end else begin
        m_frz[k] = 1'b0;
        if (mp || m_pend[k]) begin
          exp_stb[k] = S_FLUSH;
          m_left[k]  = 0;
          m_pend[k]  = 1'b0;
          m_flush[k]++;
        end else if (m_left[k] > 0) begin
          exp_stb[k] = S_BUBBLE;
          m_left[k]--;
          m_stall[k]++;
        end else if (lu) begin
          exp_stb[k] = S_BUBBLE;
          m_left[k]  = lsc[k] - 1;
          m_stall[k]++;
        end else begin
          exp_stb[k] = S_GO;
        end
      end
    end
  endtask

  // Called one time unit after a rising edge; leaves time at the next such point.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic mp,
                               input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    idex_mem_read = mr; idex_rd = rd; ex_mispredict = mp;
    mem_req = req; mem_ready = rdy;
    modelStep();
    #3;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("strobes_lsc%0d", lsc[k]), 32'(stb[k]), 32'(exp_stb[k]));
      checkOutput($sformatf("state_lsc%0d", lsc[k]), 32'(st[k]), 32'(exp_st[k]));
    end
    @(posedge clk);
    #1;
`ifdef PIPE_PERF_CNT_EN
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("stall_cycles_lsc%0d", lsc[k]), pc_stall[k], m_stall[k]);
      checkOutput($sformatf("flush_count_lsc%0d", lsc[k]), pc_flush[k], m_flush[k]);
      checkOutput($sformatf("memwait_cycles_lsc%0d", lsc[k]), pc_mw[k], m_mw[k]);
    end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges and checks the outputs collapse immediately.
  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("rst_async_strobes_lsc%0d", lsc[k]), 32'(stb[k]), 32'(S_INIT));
      checkOutput($sformatf("rst_async_state_lsc%0d", lsc[k]), 32'(st[k]), 32'd0);
    end
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle(4);
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    idle(4);

    repeat (4) applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(1);

    repeat (3) applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle(2);

    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(2);

    applyStimulus(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(4);

    applyStimulus(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    doReset();
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) doReset();
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
